irq_capture_ack: RTL and testbench

IRQ_CAPTURE_ACK -- requirements
Module: irq_capture_ack

---
 rtl/irq_capture_ack.sv | 160 ++++++++++++++++
 tb/tb_irq_capture_ack.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_capture_ack.sv
// Interrupt capture with rising-edge detect, pending/acknowledge handshake, saturating
// missed-event counters, and optional per-channel period measurement (IRQ_PERIOD_MEAS_EN).
module irq_capture_ack #(
  parameter int unsigned NUM_IRQ  = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PERIOD_W = 20
) (
  input  logic                         Sys_clk,
  input  logic                         Rst_n,
  input  logic [NUM_IRQ-1:0]           Irq_in,
  input  logic                         Ack_valid,
  input  logic [2:0]                   Ack_id,
  input  logic                         Miss_clr,
  output logic                         Irq_out,
  output logic [2:0]                   Irq_id,
  output logic [NUM_IRQ-1:0]           Pending,
  output logic                         Ack_err,
  output logic [NUM_IRQ*CNT_W-1:0]     Miss_cnt,
  output logic [NUM_IRQ*PERIOD_W-1:0]  Period,
  output logic [NUM_IRQ-1:0]           Period_vld
);

  localparam int unsigned ID_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic               ack_err_q, ack_err_d;
  logic [CNT_W-1:0]   miss_q [NUM_IRQ];
  logic [CNT_W-1:0]   miss_d [NUM_IRQ];

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_hit;
  logic [NUM_IRQ-1:0] miss;
  logic [ID_W-1:0]    irq_id_c;

  // Edge detect, acknowledge decode and pending/miss next-state.
  always_comb begin
    irq_prev_d = Irq_in;
    rise       = Irq_in & ~irq_prev_q;
    ack_hit    = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      ack_hit[i] = Ack_valid && (Ack_id == ID_W'(i)) && pending_q[i];
    end
    // A rise coinciding with a valid ack re-arms the channel and is not a miss.
    miss      = rise & pending_q & ~ack_hit;
    pending_d = rise | (pending_q & ~ack_hit);
    ack_err_d = Ack_valid && (ack_hit == '0);
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      miss_d[i] = miss_q[i];
      if (Miss_clr) begin
        miss_d[i] = miss[i] ? CNT_W'(1) : '0;
      end else if (miss[i] && (miss_q[i] != CNT_MAX)) begin
        miss_d[i] = miss_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (!Rst_n) begin
      irq_prev_q <= '0;
      pending_q  <= '0;
      ack_err_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
        miss_q[i] <= '0;
      end
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      ack_err_q  <= ack_err_d;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
        miss_q[i] <= miss_d[i];
      end
    end
  end

  // Lowest pending index wins.
  always_comb begin
    irq_id_c = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        irq_id_c = ID_W'(i);
      end
    end
  end

  always_comb begin
    Miss_cnt = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      Miss_cnt[i*CNT_W +: CNT_W] = miss_q[i];
    end
  end

  assign Irq_out = |pending_q;
  assign Irq_id  = irq_id_c;
  assign Pending = pending_q;
  assign Ack_err = ack_err_q;

`ifdef IRQ_PERIOD_MEAS_EN
  localparam logic [PERIOD_W-1:0] PER_MAX = {PERIOD_W{1'b1}};

  logic [PERIOD_W-1:0] per_cnt_q [NUM_IRQ];
  logic [PERIOD_W-1:0] per_cnt_d [NUM_IRQ];
  logic [PERIOD_W-1:0] per_val_q [NUM_IRQ];
  logic [PERIOD_W-1:0] per_val_d [NUM_IRQ];
  logic [PERIOD_W-1:0] per_inc   [NUM_IRQ];
  logic [NUM_IRQ-1:0]  per_vld_q, per_vld_d;
  logic [NUM_IRQ-1:0]  seen_q, seen_d;

  // First rise only arms the counter; each later rise latches the elapsed cycles.
  always_comb begin
    per_vld_d = per_vld_q;
    seen_d    = seen_q;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      per_inc[i]   = (per_cnt_q[i] == PER_MAX) ? PER_MAX : per_cnt_q[i] + PERIOD_W'(1);
      per_cnt_d[i] = per_inc[i];
      per_val_d[i] = per_val_q[i];
      if (rise[i]) begin
        per_cnt_d[i] = '0;
        seen_d[i]    = 1'b1;
        if (seen_q[i]) begin
          per_val_d[i] = per_inc[i];
          per_vld_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (!Rst_n) begin
      per_vld_q <= '0;
      seen_q    <= '0;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
        per_cnt_q[i] <= '0;
        per_val_q[i] <= '0;
      end
    end else begin
      per_vld_q <= per_vld_d;
      seen_q    <= seen_d;
      for (int i = 0; i < int'(NUM_IRQ); i++) begin
        per_cnt_q[i] <= per_cnt_d[i];
        per_val_q[i] <= per_val_d[i];
      end
    end
  end

  always_comb begin
    Period = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      Period[i*PERIOD_W +: PERIOD_W] = per_val_q[i];
    end
  end

  assign Period_vld = per_vld_q;
`else
  assign Period     = '0;
  assign Period_vld = '0;
`endif

endmodule

// File: tb/tb_irq_capture_ack.sv
// Bench for irq_capture_ack: directed scenarios plus randomized traffic against a
// cycle-level behavioural model (period model active when IRQ_PERIOD_MEAS_EN is defined).
module tb_irq_capture_ack;
  localparam int unsigned NUM = 2;
  localparam int unsigned CW  = 8;
  localparam int unsigned PW  = 20;
  localparam int CMAX = (1 << CW) - 1;
  localparam int PMAX = (1 << PW) - 1;

  logic              Sys_clk = 1'b0;
  logic              Rst_n;
  logic [NUM-1:0]    Irq_in;
  logic              Ack_valid;
  logic [2:0]        Ack_id;
  logic              Miss_clr;
  logic              Irq_out;
  logic [2:0]        Irq_id;
  logic [NUM-1:0]    Pending;
  logic              Ack_err;
  logic [NUM*CW-1:0] Miss_cnt;
  logic [NUM*PW-1:0] Period;
  logic [NUM-1:0]    Period_vld;

  always #5 Sys_clk = ~Sys_clk;

  irq_capture_ack #(.NUM_IRQ(NUM), .CNT_W(CW), .PERIOD_W(PW)) dut (
    .Sys_clk(Sys_clk), .Rst_n(Rst_n), .Irq_in(Irq_in), .Ack_valid(Ack_valid),
    .Ack_id(Ack_id), .Miss_clr(Miss_clr), .Irq_out(Irq_out), .Irq_id(Irq_id),
    .Pending(Pending), .Ack_err(Ack_err), .Miss_cnt(Miss_cnt), .Period(Period),
    .Period_vld(Period_vld)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: events and timestamps rather than counters.
  bit m_prev [NUM];
  bit m_pend [NUM];
  int m_miss [NUM];
  bit m_err;
  bit m_seen [NUM];
  int m_last [NUM];
  int m_per  [NUM];
  bit m_vld  [NUM];
  int cyc = 0;

  function automatic void m_step();
    bit ack_ok;
    int id;
    bit rise, miss;
    if (!Rst_n) begin
      m_err = 0;
      for (int i = 0; i < NUM; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_miss[i] = 0;
        m_seen[i] = 0; m_last[i] = 0; m_per[i] = 0; m_vld[i] = 0;
      end
      return;
    end
    id = int'(Ack_id);
    ack_ok = 0;
    if (Ack_valid && id < NUM) ack_ok = m_pend[id];
    m_err = Ack_valid && !ack_ok;
    for (int i = 0; i < NUM; i++) begin
      rise = Irq_in[i] && !m_prev[i];
      miss = rise && m_pend[i] && !(ack_ok && id == i);
      if (Miss_clr) m_miss[i] = miss ? 1 : 0;
      else if (miss) m_miss[i] = (m_miss[i] + 1 > CMAX) ? CMAX : m_miss[i] + 1;
      if (rise) m_pend[i] = 1;
      else if (ack_ok && id == i) m_pend[i] = 0;
      if (rise) begin
        if (m_seen[i]) begin
          m_per[i] = (cyc - m_last[i] > PMAX) ? PMAX : cyc - m_last[i];
          m_vld[i] = 1;
        end
        m_seen[i] = 1;
        m_last[i] = cyc;
      end
      m_prev[i] = Irq_in[i];
    end
  endfunction

  function automatic logic [NUM-1:0] exp_pend();
    logic [NUM-1:0] r = '0;
    for (int i = 0; i < NUM; i++) r[i] = m_pend[i];
    return r;
  endfunction

  function automatic logic [2:0] exp_id();
    for (int i = 0; i < NUM; i++) if (m_pend[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [NUM*CW-1:0] exp_miss();
    logic [NUM*CW-1:0] r = '0;
    for (int i = 0; i < NUM; i++) r[i*CW +: CW] = CW'(m_miss[i]);
    return r;
  endfunction

  function automatic logic [NUM*PW-1:0] exp_per();
    logic [NUM*PW-1:0] r = '0;
`ifdef IRQ_PERIOD_MEAS_EN
    for (int i = 0; i < NUM; i++) r[i*PW +: PW] = PW'(m_per[i]);
`endif
    return r;
  endfunction

  function automatic logic [NUM-1:0] exp_vld();
    logic [NUM-1:0] r = '0;
`ifdef IRQ_PERIOD_MEAS_EN
    for (int i = 0; i < NUM; i++) r[i] = m_vld[i];
`endif
    return r;
  endfunction

  task automatic tick();
    m_step();
    cyc++;
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic do_ack(input int id);
    Ack_valid = 1'b1; Ack_id = 3'(id);
    tick();
    Ack_valid = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; Irq_in = '0; Ack_valid = 1'b0; Ack_id = '0; Miss_clr = 1'b0;
    repeat (4) tick();
    n_tests++; if (Pending !== 2'b00) begin n_fail++; $display("FAIL reset_pending got %b exp 00", Pending); end
    n_tests++; if (Irq_out !== 1'b0 || Irq_id !== 3'd0) begin n_fail++; $display("FAIL reset_irq got out=%b id=%0d exp 0/0", Irq_out, Irq_id); end
    n_tests++; if (Ack_err !== 1'b0 || Miss_cnt !== '0) begin n_fail++; $display("FAIL reset_err_miss got err=%b miss=%h exp 0/0", Ack_err, Miss_cnt); end
    n_tests++; if (Period !== '0 || Period_vld !== '0) begin n_fail++; $display("FAIL reset_period got %h/%b exp 0/0", Period, Period_vld); end
  endtask

  task automatic test_single();
    Rst_n = 1'b1;
    repeat (5) tick();
    Irq_in = 2'b10;
    tick();
    n_tests++; if (Pending !== 2'b10) begin n_fail++; $display("FAIL single_pending got %b exp 10", Pending); end
    n_tests++; if (Irq_out !== 1'b1 || Irq_id !== 3'd1) begin n_fail++; $display("FAIL single_irq got out=%b id=%0d exp 1/1", Irq_out, Irq_id); end
    repeat (3) tick();
    do_ack(1);
    n_tests++; if (Pending !== 2'b00 || Ack_err !== 1'b0) begin n_fail++; $display("FAIL single_ack got pend=%b err=%b exp 00/0", Pending, Ack_err); end
    tick();
    n_tests++; if (Ack_err !== 1'b0 || Irq_out !== 1'b0) begin n_fail++; $display("FAIL single_after got err=%b out=%b exp 0/0", Ack_err, Irq_out); end
    Irq_in = '0;
    tick();
  endtask

  task automatic test_both();
    Irq_in = 2'b11;
    tick();
    n_tests++; if (Pending !== 2'b11 || Irq_id !== 3'd0) begin n_fail++; $display("FAIL both_rise got pend=%b id=%0d exp 11/0", Pending, Irq_id); end
    Irq_in = 2'b00;
    do_ack(0);
    n_tests++; if (Irq_id !== 3'd1 || Pending !== 2'b10) begin n_fail++; $display("FAIL both_ack0 got id=%0d pend=%b exp 1/10", Irq_id, Pending); end
    do_ack(1);
    n_tests++; if (Irq_out !== 1'b0 || Ack_err !== 1'b0) begin n_fail++; $display("FAIL both_ack1 got out=%b err=%b exp 0/0", Irq_out, Ack_err); end
    tick();
  endtask

  task automatic pulse0();
    Irq_in[0] = 1'b1; tick();
    Irq_in[0] = 1'b0; tick();
  endtask

  task automatic test_miss();
    repeat (3) pulse0();
    n_tests++; if (Miss_cnt[CW-1:0] !== 8'd2) begin n_fail++; $display("FAIL miss_three got %0d exp 2", Miss_cnt[CW-1:0]); end
    repeat (300) pulse0();
    n_tests++; if (Miss_cnt[CW-1:0] !== 8'd255) begin n_fail++; $display("FAIL miss_sat got %0d exp 255", Miss_cnt[CW-1:0]); end
    Miss_clr = 1'b1; tick(); Miss_clr = 1'b0;
    n_tests++; if (Miss_cnt !== '0 || Pending !== 2'b01) begin n_fail++; $display("FAIL miss_clr got %h pend=%b exp 0/01", Miss_cnt, Pending); end
    Irq_in[0] = 1'b1; Miss_clr = 1'b1; tick(); Miss_clr = 1'b0;
    n_tests++; if (Miss_cnt[CW-1:0] !== 8'd1) begin n_fail++; $display("FAIL miss_clr_same got %0d exp 1", Miss_cnt[CW-1:0]); end
    Irq_in[0] = 1'b0; tick();
    do_ack(0);
    tick();
  endtask

  task automatic test_ack_err();
    do_ack(1);
    n_tests++; if (Ack_err !== 1'b1 || Pending !== 2'b00) begin n_fail++; $display("FAIL err_nonpend got err=%b pend=%b exp 1/00", Ack_err, Pending); end
    tick();
    n_tests++; if (Ack_err !== 1'b0) begin n_fail++; $display("FAIL err_width got %b exp 0", Ack_err); end
    do_ack(5);
    n_tests++; if (Ack_err !== 1'b1 || Pending !== 2'b00) begin n_fail++; $display("FAIL err_range got err=%b pend=%b exp 1/00", Ack_err, Pending); end
    tick();
    pulse0();
    Irq_in[0] = 1'b1; Ack_valid = 1'b1; Ack_id = 3'd0;
    tick();
    Ack_valid = 1'b0;
    n_tests++; if (Pending !== 2'b01 || Ack_err !== 1'b0) begin n_fail++; $display("FAIL rise_ack_pend got pend=%b err=%b exp 01/0", Pending, Ack_err); end
    n_tests++; if (Miss_cnt[CW-1:0] !== 8'd1) begin n_fail++; $display("FAIL rise_ack_miss got %0d exp 1", Miss_cnt[CW-1:0]); end
    Irq_in = '0; tick();
    do_ack(0);
  endtask

  task automatic test_reset_mid();
    Irq_in = 2'b11; tick(); Irq_in = 2'b00; tick(); Irq_in = 2'b11; tick();
    n_tests++; if (Pending !== 2'b11 || Miss_cnt === '0) begin n_fail++; $display("FAIL mid_setup got pend=%b miss=%h exp 11/nonzero", Pending, Miss_cnt); end
    Rst_n = 1'b0; tick(); Rst_n = 1'b1;
    n_tests++; if (Pending !== '0 || Irq_out !== 1'b0 || Irq_id !== 3'd0 || Miss_cnt !== '0 || Ack_err !== 1'b0 || Period_vld !== '0) begin
      n_fail++; $display("FAIL mid_reset got pend=%b out=%b id=%0d miss=%h err=%b vld=%b exp all 0", Pending, Irq_out, Irq_id, Miss_cnt, Ack_err, Period_vld);
    end
    tick();
    n_tests++; if (Pending !== 2'b11) begin n_fail++; $display("FAIL mid_release got %b exp 11", Pending); end
    tick();
    n_tests++; if (Pending !== 2'b11 || Miss_cnt !== '0) begin n_fail++; $display("FAIL mid_single_rise got pend=%b miss=%h exp 11/0", Pending, Miss_cnt); end
    Irq_in = '0; tick();
    do_ack(0); do_ack(1);
  endtask

  task automatic test_period();
    for (int c = 0; c < 100; c++) begin
      Irq_in[0] = ((c % 30) < 2);
      Irq_in[1] = ((c % 7) < 3);
      Ack_valid = 1'b1; Ack_id = 3'(c % 2);
      tick();
    end
    Ack_valid = 1'b0; Irq_in = '0;
    tick();
`ifdef IRQ_PERIOD_MEAS_EN
    n_tests++; if (Period[PW-1:0] !== 20'd30 || Period[2*PW-1:PW] !== 20'd7) begin n_fail++; $display("FAIL period_val got %0d/%0d exp 30/7", Period[PW-1:0], Period[2*PW-1:PW]); end
    n_tests++; if (Period_vld !== 2'b11) begin n_fail++; $display("FAIL period_vld got %b exp 11", Period_vld); end
`else
    n_tests++; if (Period !== '0 || Period_vld !== '0) begin n_fail++; $display("FAIL period_off got %h/%b exp 0/0", Period, Period_vld); end
`endif
    do_ack(0); do_ack(1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      Rst_n     = ($urandom_range(0, 199) != 0);
      Irq_in    = NUM'($urandom);
      Ack_valid = ($urandom_range(0, 9) < 4);
      Ack_id    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, NUM - 1)) : 3'($urandom_range(0, 7));
      Miss_clr  = ($urandom_range(0, 49) == 0);
      tick();
      n_tests++;
      if (Pending !== exp_pend() || Irq_out !== (|exp_pend()) || Irq_id !== exp_id() || Ack_err !== m_err) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc=%0d got pend=%b out=%b id=%0d err=%b exp pend=%b id=%0d err=%b",
                 cyc, Pending, Irq_out, Irq_id, Ack_err, exp_pend(), exp_id(), m_err);
      end
      n_tests++;
      if (Miss_cnt !== exp_miss() || Period !== exp_per() || Period_vld !== exp_vld()) begin
        n_fail++;
        $display("FAIL rand_data cyc=%0d got miss=%h per=%h vld=%b exp miss=%h per=%h vld=%b",
                 cyc, Miss_cnt, Period, Period_vld, exp_miss(), exp_per(), exp_vld());
      end
    end
    Rst_n = 1'b1; Ack_valid = 1'b0; Miss_clr = 1'b0; Irq_in = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_miss();
    test_ack_err();
    test_reset_mid();
    test_period();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
